mpsoc_shared_mem_arbiter: RTL
=============================

Name: mpsoc_shared_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter placed directly upstream of the shared single-port on-chip memory (32-bit data, 15-bit word address, 25600 words).
- Lets the two MPSoC processor data masters share that memory.
- Issues at most one access per cycle using round-robin priority.
- Routes 1-cycle-latency read data back to the issuing master and blocks out-of-range accesses.

Parameters:
- ADDR_W, 15, word-address width on all ports.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- DEPTH, 25600, number of implemented memory words; valid addresses are 0..DEPTH-1.
- STALL_W, 16, width of the contention counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_byteenable  in  BE_W  master 0 byte lanes.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 must hold its request.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  m0_readdata valid.
- m1_*  same seven signals as m0_*, for master 1.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  BE_W  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_clken  out  1  to memory clken; constant 1.
- mem_reset_req  out  1  to memory reset_req; equals ~reset_n.
- mem_readdata  in  DATA_W  from memory readdata (unregistered q, valid the cycle after address capture).
- stall_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  STALL_W  saturating count of cycles with at least one master stalled.
- oor_err  out  1  sticky flag: out-of-range or read+write-together access seen.

Behaviour:
- Request definition: reqN = mN_read | mN_write. Read and write both high counts as a write and sets oor_err.
- Grant is combinational in the same cycle:
  - Only one master requesting: that master wins.
  - Both requesting: the master other than last_grant wins.
  - last_grant updates at the clock edge of every granted cycle.
- Waitrequest: mN_waitrequest = reqN & ~grantN. A stalled master holds address, data and controls until its waitrequest is low. An idle master sees waitrequest low.
- Memory side in a granted cycle:
  - mem_address, mem_byteenable and mem_writedata come from the winner.
  - mem_chipselect = 1 and mem_write = winner write.
  - With no grant: mem_chipselect = 0, mem_write = 0, other mem_* outputs driven 0.
- Out-of-range (address >= DEPTH):
  - The grant is still given and the master's waitrequest goes low, but mem_chipselect and mem_write are forced to 0.
  - oor_err is set at the next edge.
  - For a read, readdatavalid is still returned with readdata = 0.
- Read return, latency 1:
  - Registered flags rd_pend_N and rd_oor are set at the edge of a granted read.
  - In the next cycle mN_readdatavalid = rd_pend_N and mN_readdata = rd_oor ? 0 : mem_readdata.
  - readdata for the master with no pending read = 0.
- Writes: complete in the granted cycle with no response.
- Back-to-back: a new grant may issue in the same cycle a previous read returns. Full throughput is one access per cycle.
- stall_cnt: increments at each edge where (m0_waitrequest | m1_waitrequest) = 1, and saturates at all ones. stall_clr has priority over increment and clears the counter to 0.
- oor_err: sticky; only reset clears it.
- Reset (asynchronous, any time, including mid-read):
  - Clears rd_pend_0, rd_pend_1, rd_oor, stall_cnt and oor_err.
  - Sets last_grant = 1, so master 0 wins the first tie.
  - All readdatavalid go 0 immediately and any in-flight read is discarded.
  - mem_reset_req = 1 while reset_n = 0.
- While in reset, all outputs are 0 except mem_clken = 1 and mem_reset_req = 1.

Test Plan:
- Reset, then m0 writes 0xCAFEBABE to address 0x0010 with be=0xF, then reads 0x0010 -> m0_waitrequest = 0 both cycles; m0_readdatavalid = 1 exactly one cycle after the read with m0_readdata = 0xCAFEBABE; m1_readdatavalid stays 0.
- Both masters issue reads every cycle for 6 cycles after reset -> grants alternate m0, m1, m0, m1, …; each master sees waitrequest high on alternate cycles; stall_cnt = 6 after the burst; each readdatavalid returns the correct word.
- m1 reads address 25600 (0x6400) -> mem_chipselect = 0 that cycle; m1_readdatavalid = 1 next cycle with readdata = 0x00000000; oor_err = 1 and stays set.
- m0 writes 0x11223344 with be=0x3 over a word holding 0xFFFFFFFF, then reads it -> 0xFFFF3344.
- Granted read at cycle N, reset_n pulled low during cycle N+1 -> m0_readdatavalid goes 0 asynchronously; after release, stall_cnt = 0, oor_err = 0, and the first tie goes to m0.
- Hold stall_cnt at 0xFFFE with continuous contention -> it reaches 0xFFFF and holds there; stall_clr = 1 for one cycle -> 0x0000 at the next edge even with contention present.

Source files
------------

// File: rtl/mpsoc_shared_mem_arbiter_if.sv
// Avalon-MM master port bundle for one processor data master feeding the shared-memory arbiter.
// The arbiter uses the slave modport; each master (or bench driver) uses the master modport.
interface mpsoc_shared_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mpsoc_shared_mem_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share one single-port on-chip RAM.
// Issues one access per cycle, returns latency-1 read data to the issuer, blocks out-of-range words.
module mpsoc_shared_mem_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4,
  parameter int DEPTH   = 25600,
  parameter int STALL_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mpsoc_shared_mem_arbiter_if.slave m0,
  mpsoc_shared_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [BE_W-1:0]       mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  output logic                  mem_reset_req,
  input  logic [DATA_W-1:0]     mem_readdata,
  input  logic                  stall_clr,
  output logic [STALL_W-1:0]    stall_cnt,
  output logic                  oor_err
);

  localparam logic [ADDR_W:0]    DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic               last_grant_q, last_grant_d;
  logic               rd_pend_0_q, rd_pend_0_d;
  logic               rd_pend_1_q, rd_pend_1_d;
  logic               rd_oor_q, rd_oor_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               oor_err_q, oor_err_d;

  logic              req0, req1, grant0, grant1, any_grant;
  logic              wait0, wait1;
  logic [ADDR_W-1:0] win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;
  logic              win_read, win_write, win_rd, win_oor, win_bad;

  always_comb begin
    // Requests are masked while in reset so every master-facing output reads 0.
    req0 = reset_n & (m0.read | m0.write);
    req1 = reset_n & (m1.read | m1.write);
    // last_grant_q = 1 means master 1 won last, so master 0 takes the tie.
    grant0    = req0 & (~req1 | last_grant_q);
    grant1    = req1 & ~grant0;
    any_grant = grant0 | grant1;
    wait0     = req0 & ~grant0;
    wait1     = req1 & ~grant1;

    win_addr  = grant1 ? m1.address    : m0.address;
    win_be    = grant1 ? m1.byteenable : m0.byteenable;
    win_wdata = grant1 ? m1.writedata  : m0.writedata;
    win_read  = grant1 ? m1.read       : m0.read;
    win_write = grant1 ? m1.write      : m0.write;
    win_rd    = win_read & ~win_write;
    win_oor   = {1'b0, win_addr} >= DEPTH_W;
    win_bad   = win_oor | (win_read & win_write);

    mem_address    = any_grant ? win_addr  : '0;
    mem_byteenable = any_grant ? win_be    : '0;
    mem_writedata  = any_grant ? win_wdata : '0;
    mem_chipselect = any_grant & ~win_oor;
    mem_write      = any_grant & win_write & ~win_oor;
    mem_clken      = 1'b1;
    mem_reset_req  = ~reset_n;

    last_grant_d = any_grant ? grant1 : last_grant_q;
    rd_pend_0_d  = grant0 & win_rd;
    rd_pend_1_d  = grant1 & win_rd;
    rd_oor_d     = any_grant & win_rd & win_oor;
    oor_err_d    = oor_err_q | (any_grant & win_bad);

    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if ((wait0 | wait1) && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_pend_0_q  <= 1'b0;
      rd_pend_1_q  <= 1'b0;
      rd_oor_q     <= 1'b0;
      stall_cnt_q  <= '0;
      oor_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_0_q  <= rd_pend_0_d;
      rd_pend_1_q  <= rd_pend_1_d;
      rd_oor_q     <= rd_oor_d;
      stall_cnt_q  <= stall_cnt_d;
      oor_err_q    <= oor_err_d;
    end
  end

  assign m0.waitrequest   = wait0;
  assign m1.waitrequest   = wait1;
  assign m0.readdatavalid = rd_pend_0_q;
  assign m1.readdatavalid = rd_pend_1_q;
  // Out-of-range reads return zero instead of whatever the RAM q holds.
  assign m0.readdata      = (rd_pend_0_q & ~rd_oor_q) ? mem_readdata : '0;
  assign m1.readdata      = (rd_pend_1_q & ~rd_oor_q) ? mem_readdata : '0;
  assign stall_cnt        = stall_cnt_q;
  assign oor_err          = oor_err_q;

endmodule
